// File: rtl/elf_keypad.sv
// PS/2 key events to COSMAC ELF front-panel controls: hex toggle switches, IN button and
// LOAD/RUN/MP switch levels.
module elf_keypad #(
    parameter logic [15:0] IN_HOLD   = 16'd40000,
    parameter logic [7:0]  INIT_DATA = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic [7:0]  sw_data,
    output logic        key_strobe,
    output logic        in_btn,
    output logic        sw_load,
    output logic        sw_run,
    output logic        sw_mp
);

    typedef enum logic [1:0] {StIdle, StPressed, StHold} in_state_e;

    in_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        primed_q, primed_d;
    logic        toggle_q, toggle_d;
    logic [7:0]  data_q, data_d;
    logic        strobe_q, strobe_d;
    logic        load_q, load_d;
    logic        run_q, run_d;
    logic        mp_q, mp_d;

    logic        key_event;
    logic        key_press;
    logic        key_ext;
    logic [7:0]  code;
    logic        is_digit;
    logic [3:0]  digit;
    logic        enter_press;
    logic        enter_release;

    // primed_q suppresses whatever toggle level happens to be on the bus at reset release
    assign key_event     = primed_q && (ps2_key[10] != toggle_q);
    assign key_press     = ps2_key[9];
    assign key_ext       = ps2_key[8];
    assign code          = ps2_key[7:0];
    assign enter_press   = key_event && (code == 8'h5A) && key_press;
    assign enter_release = key_event && (code == 8'h5A) && !key_press;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'h0;
        case (code)
            8'h45:   digit = 4'h0;
            8'h16:   digit = 4'h1;
            8'h1E:   digit = 4'h2;
            8'h26:   digit = 4'h3;
            8'h25:   digit = 4'h4;
            8'h2E:   digit = 4'h5;
            8'h36:   digit = 4'h6;
            8'h3D:   digit = 4'h7;
            8'h3E:   digit = 4'h8;
            8'h46:   digit = 4'h9;
            8'h1C:   digit = 4'hA;
            8'h32:   digit = 4'hB;
            8'h21:   digit = 4'hC;
            8'h23:   digit = 4'hD;
            8'h24:   digit = 4'hE;
            8'h2B:   digit = 4'hF;
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        primed_d = 1'b1;
        toggle_d = ps2_key[10];
        data_d   = data_q;
        strobe_d = 1'b0;
        load_d   = load_q;
        run_d    = run_q;
        mp_d     = mp_q;
        if (key_event && key_press && !key_ext) begin
            if (is_digit) begin
                data_d   = {data_q[3:0], digit};
                strobe_d = 1'b1;
            end else begin
                case (code)
                    8'h66:   data_d = INIT_DATA;
                    8'h4B:   load_d = ~load_q;
                    8'h2D:   run_d  = ~run_q;
                    8'h3A:   mp_d   = ~mp_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed_q <= 1'b0;
            toggle_q <= 1'b0;
            data_q   <= INIT_DATA;
            strobe_q <= 1'b0;
            load_q   <= 1'b0;
            run_q    <= 1'b0;
            mp_q     <= 1'b0;
        end else begin
            primed_q <= primed_d;
            toggle_q <= toggle_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            load_q   <= load_d;
            run_q    <= run_d;
            mp_q     <= mp_d;
        end
    end

    // IN button FSM: state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q >= IN_HOLD) ? cnt_q : cnt_q + 16'd1;

    // cnt counts high cycles already spent; leaving at cnt_inc == IN_HOLD gives IN_HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enter_press) begin
                    state_d = StPressed;
                end
            end
            StPressed: begin
                cnt_d = cnt_inc;
                if (enter_release) begin
                    state_d = (cnt_inc >= IN_HOLD) ? StIdle : StHold;
                end
            end
            StHold: begin
                cnt_d = cnt_inc;
                if (enter_press) begin
                    state_d = StPressed;
                end else if (cnt_inc >= IN_HOLD) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_btn = (state_q != StIdle);
    end

    assign sw_data    = data_q;
    assign key_strobe = strobe_q;
    assign sw_load    = load_q;
    assign sw_run     = run_q;
    assign sw_mp      = mp_q;

endmodule

// File: tb/tb_elf_keypad.sv
// Bench for elf_keypad: directed scenarios plus random key traffic against an
// event-level reference model.
module tb_elf_keypad;

    localparam logic [15:0] HOLD = 16'd8;
    localparam logic [7:0]  INIT = 8'h00;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [7:0]  sw_data;
    logic        key_strobe, in_btn, sw_load, sw_run, sw_mp;

    always #5 clk_sys = ~clk_sys;

    elf_keypad #(
        .IN_HOLD  (HOLD),
        .INIT_DATA(INIT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .sw_data   (sw_data),
        .key_strobe(key_strobe),
        .in_btn    (in_btn),
        .sw_load   (sw_load),
        .sw_run    (sw_run),
        .sw_mp     (sw_mp)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          hi_cnt   = 0;

    logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    // Reference model: key-event semantics plus IN-button on/off edge timestamps
    logic       m_primed, m_prev;
    logic [7:0] m_data;
    logic       m_strobe, m_load, m_run, m_mp, m_btn;
    bit         m_active, m_held;
    int         m_cyc = 0;
    int         m_on, m_off;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    function automatic int digit_of(input logic [7:0] c);
        for (int i = 0; i < 16; i++) if (hex_codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_primed = 1'b0;
        m_prev   = 1'b0;
        m_data   = INIT;
        m_strobe = 1'b0;
        m_load   = 1'b0;
        m_run    = 1'b0;
        m_mp     = 1'b0;
        m_btn    = 1'b0;
        m_active = 1'b0;
        m_held   = 1'b0;
        m_on     = 0;
        m_off    = 0;
    endtask

    task automatic model_edge();
        bit         ev, now_high, press, ext;
        logic [7:0] c;
        int         d, n;
        n = m_cyc + 1;
        if (!reset_n) begin
            model_reset();
            m_cyc = n;
            return;
        end
        ev       = m_primed && (ps2_key[10] != m_prev);
        m_prev   = ps2_key[10];
        m_primed = 1'b1;
        m_strobe = 1'b0;
        now_high = m_active && (m_held || m_cyc < m_off);
        if (ev) begin
            c     = ps2_key[7:0];
            press = ps2_key[9];
            ext   = ps2_key[8];
            if (c == 8'h5A) begin
                if (press) begin
                    if (!now_high) begin
                        m_active = 1'b1;
                        m_on     = n;
                    end
                    m_held = 1'b1;
                end else if (now_high && m_held) begin
                    m_held = 1'b0;
                    m_off  = (n > m_on + int'(HOLD)) ? n : m_on + int'(HOLD);
                end
            end else if (press && !ext) begin
                d = digit_of(c);
                if (d >= 0) begin
                    m_data   = {m_data[3:0], d[3:0]};
                    m_strobe = 1'b1;
                end else if (c == 8'h66) m_data = INIT;
                else if (c == 8'h4B) m_load = ~m_load;
                else if (c == 8'h2D) m_run = ~m_run;
                else if (c == 8'h3A) m_mp = ~m_mp;
            end
        end
        m_btn = m_active && (m_held || n < m_off);
        m_cyc = n;
    endtask

    task automatic check_all();
        check("sw_data", 32'(sw_data), 32'(m_data));
        check("key_strobe", 32'(key_strobe), 32'(m_strobe));
        check("in_btn", 32'(in_btn), 32'(m_btn));
        check("sw_load", 32'(sw_load), 32'(m_load));
        check("sw_run", 32'(sw_run), 32'(m_run));
        check("sw_mp", 32'(sw_mp), 32'(m_mp));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        if (in_btn) hi_cnt++;
        check_all();
    endtask

    task automatic send(input logic [7:0] c, input bit press, input bit ext);
        ps2_key = {~ps2_key[10], press, ext, c};
        tick();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset_n = 1'b1;
    endtask

    logic [7:0] pool [22] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                              8'h66, 8'h4B, 8'h2D, 8'h3A, 8'h5A, 8'h5A};

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_data", 32'(sw_data), 32'(INIT));
        check("rst_btn", 32'(in_btn), 32'd0);
        reset_n = 1'b1;
        tick();

        // two digits shift in, one strobe each
        send(8'h16, 1'b1, 1'b0);
        check("t1_strobe1", 32'(key_strobe), 32'd1);
        send(8'h2B, 1'b1, 1'b0);
        check("t1_strobe2", 32'(key_strobe), 32'd1);
        check("t1_data", 32'(sw_data), 32'h1F);
        tick();
        check("t1_strobe_off", 32'(key_strobe), 32'd0);

        // bus toggle already high at reset release is not an event
        reset_n = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h45};
        #1;
        model_reset();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t2_no_event", 32'(key_strobe), 32'd0);
        check("t2_data", 32'(sw_data), 32'h00);
        send(8'h45, 1'b1, 1'b0);
        check("t2_strobe", 32'(key_strobe), 32'd1);
        check("t2_data2", 32'(sw_data), 32'h00);

        // short Enter press stretched to HOLD cycles
        hi_cnt = 0;
        send(8'h5A, 1'b1, 1'b0);
        repeat (2) tick();
        send(8'h5A, 1'b0, 1'b0);
        repeat (12) tick();
        check("t3_short_len", 32'(hi_cnt), 32'(HOLD));
        // long Enter press drops one cycle after release
        hi_cnt = 0;
        send(8'h5A, 1'b1, 1'b1);
        repeat (19) tick();
        send(8'h5A, 1'b0, 1'b1);
        check("t3_long_drop", 32'(in_btn), 32'd0);
        check("t3_long_len", 32'(hi_cnt), 32'd20);
        repeat (2) tick();

        // switch toggles; releases ignored
        send(8'h4B, 1'b1, 1'b0);
        send(8'h2D, 1'b1, 1'b0);
        send(8'h4B, 1'b1, 1'b0);
        send(8'h3A, 1'b1, 1'b0);
        send(8'h4B, 1'b0, 1'b0);
        send(8'h2D, 1'b0, 1'b0);
        send(8'h3A, 1'b0, 1'b0);
        check("t4_sw", 32'({sw_load, sw_run, sw_mp}), 32'b011);

        // backspace and extended digit
        send(8'h1C, 1'b1, 1'b0);
        send(8'h2E, 1'b1, 1'b0);
        check("t5_a5", 32'(sw_data), 32'hA5);
        send(8'h1C, 1'b1, 1'b1);
        check("t5_ext", 32'(sw_data), 32'hA5);
        send(8'h66, 1'b1, 1'b0);
        check("t5_bksp", 32'(sw_data), 32'(INIT));

        // reset while Enter held; trailing release does nothing
        send(8'h5A, 1'b1, 1'b0);
        tick();
        check("t6_held", 32'(in_btn), 32'd1);
        pulse_reset();
        check("t6_rst", 32'(in_btn), 32'd0);
        send(8'h5A, 1'b0, 1'b0);
        repeat (3) tick();
        check("t6_after", 32'(in_btn), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                if ($urandom_range(0, 1) == 1) ps2_key[10] = ~ps2_key[10];
                pulse_reset();
            end else if (r < 90) begin
                logic [7:0] c;
                if ($urandom_range(0, 9) == 0) c = 8'($urandom);
                else c = pool[$urandom_range(0, 21)];
                send(c, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elf_keypad.md
Name: elf_keypad

Overview:
- Converts MiSTer PS/2 key events into the COSMAC ELF front-panel controls.
- Drives the 8-bit toggle-switch byte, the IN pushbutton (EF4) and the LOAD/RUN/MP switches.
- Sits upstream of the cosmacelf machine core and consumes the `ps2_key` bus from hps_io in the emu top.

Parameters:
- IN_HOLD, 16'd40000: minimum number of clk_sys cycles that in_btn stays asserted after an Enter press (debounce/stretch for CPU polling).
- INIT_DATA, 8'h00: value of sw_data after reset and after Backspace.

Ports:
- clk_sys  in  1  system clock (same as core clk).
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  hps_io key bus: [10] toggles on every event, [9] 1=press/0=release, [8] extended (E0), [7:0] set-2 scancode.
- sw_data  out  8  toggle-switch byte presented on the CPU input port.
- key_strobe  out  1  one-cycle pulse when a hex digit has been shifted into sw_data.
- in_btn  out  1  IN pushbutton, active high; the core maps it to EF4.
- sw_load  out  1  LOAD switch level.
- sw_run  out  1  RUN switch level.
- sw_mp  out  1  memory-protect switch level.

Behaviour:
- Reset (async, reset_n=0):
  - sw_data=INIT_DATA; key_strobe, in_btn, sw_load, sw_run and sw_mp all 0.
  - IN FSM returns to IDLE; hold counter=0; primed=0.
- Event detection:
  - toggle_prev is registered from ps2_key[10].
  - First clock after reset release: sets primed=1 and loads toggle_prev without producing an event, so the current bit state never triggers a spurious key.
  - With primed=1, ps2_key[10] != toggle_prev produces an event. The event is decoded the same cycle from the ps2_key value; outputs update on the next edge (1-cycle latency).
  - At most one event per cycle. No queueing: hps_io cannot issue events faster.
- Hex digits (press only, ps2_key[8]=0):
  - Scancodes: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9, 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F.
  - Action: sw_data <= {sw_data[3:0], digit}; key_strobe=1 for exactly one cycle.
  - Releases of digit keys are ignored.
- Backspace 66 (press): sw_data <= INIT_DATA; no strobe.
- Switch toggles (press, non-extended): L(4B) inverts sw_load, R(2D) inverts sw_run, M(3A) inverts sw_mp. Releases are ignored. Combinations such as load=run=1 are passed through unmodified; the core arbitrates.
- Enter: 5A with ps2_key[8] either 0 or 1 (main or keypad Enter). IN FSM:
  - IDLE: in_btn=0. On Enter press → PRESSED, in_btn=1, cnt=0.
  - PRESSED: cnt increments, saturating at IN_HOLD. On Enter release: if cnt>=IN_HOLD → IDLE, else → HOLD.
  - HOLD: in_btn=1, cnt increments; → IDLE when cnt==IN_HOLD.
  - Enter press while in HOLD → PRESSED, cnt not reset (no glitch low).
  - Enter press while already PRESSED (typematic repeat) → no effect.
  - Release seen in IDLE → ignored.
- Other extended keys and unlisted scancodes: no effect on any output.
- Counter is 16 bits and saturating; it never wraps.
- reset_n asserted mid-press: all outputs clear immediately. The following event is treated as first-after-reset (primed logic), so a pending release produces nothing.

Test Plan:
- After reset, toggle ps2_key[10] with press 16 then press 2B → sw_data=8'h1F; key_strobe pulses twice, 1 cycle each, each 1 cycle after its event.
- Reset released while ps2_key[10]=1 with scancode 45 press held on bus → no event, sw_data stays 8'h00. Next toggle with 45 press → sw_data=8'h00, key_strobe=1.
- IN_HOLD=8: Enter press then release 3 cycles later → in_btn high for exactly 8 cycles after the press-plus-1 edge. Release after 20 cycles → in_btn drops 1 cycle after the release event.
- Press L, R, L, M → sw_load=0, sw_run=1, sw_mp=1. The matching release events leave all three unchanged.
- sw_data=8'hA5, press 66 → 8'h00. Extended E0 1C press → no change.
- Enter held (PRESSED); assert reset_n=0 for 1 cycle; then Enter release event → in_btn=0 throughout, FSM stays IDLE.
